// File: rtl/qupls_alu_dispatch_fifo.sv
// In-order dispatch FIFO between the ALU-classification decode stage and the ALU reservation station.
// Absorbs reservation-station back-pressure, supports flush, and counts dispatched ALU ops.
module qupls_alu_dispatch_fifo #(
  parameter int DEPTH = 4,
  parameter int IW    = 48,
  parameter int TW    = 6
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       flush,
  input  logic                       dec_valid,
  input  logic                       dec_alu,
  input  logic [IW-1:0]              dec_instr,
  input  logic [TW-1:0]              dec_tag,
  output logic                       dec_ready,
  output logic                       alu_valid,
  output logic [IW-1:0]              alu_instr,
  output logic [TW-1:0]              alu_tag,
  input  logic                       alu_ready,
  output logic [$clog2(DEPTH):0]     count,
  output logic [31:0]                disp_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef struct packed {
    logic [IW-1:0] instr;
    logic [TW-1:0] tag;
  } entry_t;

  entry_t        mem [DEPTH];
  logic [AW-1:0] rp;
  logic [AW-1:0] wp;
  logic          push;
  logic          pop;

  // Readiness depends only on registered occupancy, so a full FIFO never takes
  // a push in the same cycle it pops; this keeps dec_ready off the alu_ready path.
  assign dec_ready = (count != CW'(DEPTH));
  assign alu_valid = (count != '0);
  assign push      = dec_valid & dec_alu & dec_ready & ~flush;
  assign pop       = alu_valid & alu_ready & ~flush;

  assign alu_instr = mem[rp].instr;
  assign alu_tag   = mem[rp].tag;

  // NOTE: the array is reset here because the head outputs must read as zero
  // during reset; without that requirement it would be left unreset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (push) begin
      mem[wp] <= '{instr: dec_instr, tag: dec_tag};
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rp    <= '0;
      wp    <= '0;
      count <= '0;
    end else if (flush) begin
      rp    <= '0;
      wp    <= '0;
      count <= '0;
    end else begin
      if (push) wp <= wp + 1'b1;
      if (pop)  rp <= rp + 1'b1;
      unique case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Performance counter survives flush; only reset clears it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)   disp_cnt <= '0;
    else if (pop) disp_cnt <= disp_cnt + 32'd1;
  end

endmodule

// File: doc/qupls_alu_dispatch_fifo.md
# qupls_alu_dispatch_fifo

Buffers decoded instructions that the decoder's ALU classifier marks as ALU ops, and presents them in program order to the ALU reservation station over a valid/ready handshake. Sits directly downstream of the ALU-classification decode stage and upstream of ALU issue. It absorbs reservation-station back-pressure so the decoder stalls only when the FIFO is full. It also supports pipeline flush and keeps a wrapping count of dispatched ALU ops for performance monitoring.

## Interface
Parameters:
- DEPTH, 4: number of FIFO entries; power of two, 2..16.
- IW, 48: instruction width in bits.
- TW, 6: reorder-buffer tag width in bits.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- flush  in  1  discard all buffered entries.
- dec_valid  in  1  decoder presents an instruction.
- dec_alu  in  1  classifier output: the instruction is an ALU op.
- dec_instr  in  IW  instruction bits.
- dec_tag  in  TW  ROB tag.
- dec_ready  out  1  FIFO can accept an ALU op this cycle.
- alu_valid  out  1  head entry is valid.
- alu_instr  out  IW  head instruction.
- alu_tag  out  TW  head tag.
- alu_ready  in  1  reservation station accepts the head.
- count  out  $clog2(DEPTH)+1  current occupancy.
- disp_cnt  out  32  number of ALU ops popped; wraps modulo 2^32.

## Operation
- push = dec_valid & dec_alu & dec_ready & !flush.
- A dec_valid with dec_alu=0 is ignored: no push, no effect on dec_ready.
- pop = alu_valid & alu_ready & !flush.
- Storage: DEPTH-entry register array. Read pointer rp and write pointer wp are each $clog2(DEPTH) bits and wrap naturally modulo DEPTH.
- On push, write {dec_instr, dec_tag} at wp, then wp <= wp+1.
- On pop, rp <= rp+1.
- count: +1 on push only, -1 on pop only, unchanged when push and pop occur together or when neither occurs.
- dec_ready = (count != DEPTH). It is a combinational function of the registered count and does not depend on alu_ready, so a full FIFO does not accept a push in the same cycle as a pop.
- alu_valid = (count != 0). alu_instr and alu_tag are driven from the entry at rp.
- While alu_valid=1 and alu_ready=0, alu_instr and alu_tag hold stable.
- Flush, registered: on the next edge rp, wp and count become 0. Any push or pop in the flush cycle is suppressed. Array contents are don't-care.
- disp_cnt increments by 1 on every pop. Flush does not clear it.
- Reset, asynchronous, while rst_n=0:
  - rp, wp and count are 0, so dec_ready=1 and alu_valid=0.
  - disp_cnt is 0.
  - alu_instr and alu_tag are 0; the array is cleared.
- Reset asserted mid-transfer discards all entries immediately. It is not required to be glitch-free with respect to in-flight handshakes.
- Both handshakes are plain valid/ready. The FIFO never drops an accepted entry except on flush or reset.

## Timing
- Latency: an entry pushed at edge N is visible on alu_valid at N+1. There is no same-cycle bypass.
- Throughput: one push and one pop per cycle sustained when 0 < count < DEPTH.
- Full boundary: with count=DEPTH, dec_ready=0. A pop at edge N makes count=DEPTH-1 and dec_ready=1 in cycle N+1.
- Empty boundary: with count=0, alu_valid=0 and pop is impossible. A push at edge N makes alu_valid=1 in cycle N+1.
- Simultaneous push and pop at count=1: count stays 1 and the head advances to the newly written entry.
- Pointer wrap: after DEPTH pushes, wp returns to 0. Ordering is preserved across the wrap.
- Flush together with push and pop: the flush wins, and count=0 after the edge.
- rst_n deassertion is synchronized externally. The first push is accepted on the first edge with rst_n=1.

## Test plan
- Reset: hold rst_n=0 for 3 cycles, release -> dec_ready=1, alu_valid=0, count=0, disp_cnt=0.
- Fill and drain: with alu_ready=0, push 4 ALU ops with tags 1..4 -> count=4 and dec_ready=0; a fifth dec_valid is not accepted. Then set alu_ready=1 -> tags 1,2,3,4 pop on consecutive cycles and disp_cnt=4.
- Filtering: present 6 instructions alternating dec_alu=1/0 with alu_ready=0 -> count=3, and the stored tags are the three ALU ones in order.
- Streaming with wrap: alu_ready=1, push 10 ops back-to-back with tags 0..9 -> each appears one cycle after its push, in order, count never exceeds 1, and disp_cnt=10.
- Back-pressure stability: with count=2, toggle alu_ready 0/1 every cycle -> the head stays stable while alu_ready=0, and no entry is duplicated or lost.
- Flush: with count=3, assert flush in a cycle with dec_valid=dec_alu=1 and alu_ready=1 -> next cycle count=0 and alu_valid=0, disp_cnt is unchanged, and the next push appears at the head.
